// File: rtl/countdown_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_ctrl_if
//  Description : Control/status bundle for the countdown controller.
//                master = button/pulse side (drives commands, reads status)
//                slave  = countdown_ctrl (reads commands, drives status)
//  Signals     : load, load_val[WIDTH], start, pause, repeat_en   (commands)
//                count[WIDTH], busy, done, state[2]              (status)
//  Revision    : 1.0 - initial release
// ============================================================================
interface countdown_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             repeat_en;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output load, load_val, start, pause, repeat_en,
        input  count, busy, done, state
    );

    modport slave (
        input  load, load_val, start, pause, repeat_en,
        output count, busy, done, state
    );
endinterface
`default_nettype wire

// File: rtl/countdown_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_ctrl
//  Description : Sequencer for a WIDTH-bit down counter. Loads a start value,
//                decrements once every PRESCALE cycles while running,
//                supports pause/resume, single-shot or auto-repeat, and
//                emits a one-cycle done pulse at terminal count.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous active-high reset
//                bus    - countdown_ctrl_if.slave
//                         in : load, load_val, start, pause, repeat_en
//                         out: count, busy, done, state (all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    countdown_ctrl_if.slave    bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    c_presc_max = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q,  presc_d;
    logic             done_q,   done_d;
    logic             busy_q,   busy_d;

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        done_d   = 1'b0;

        if (bus.load) begin
            // Highest priority: pause/start in the same cycle are dropped.
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            presc_d  = '0;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.pause) begin
                        // Freeze presc and count; a tick due now is lost.
                        state_d = ST_PAUSE;
                    end else if (presc_q == c_presc_max) begin
                        presc_d = '0;
                        if (count_q > c_one) begin
                            count_d = count_q - c_one;
                        end else if (count_q == c_one) begin
                            done_d = 1'b1;
                            if (bus.repeat_en) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end
                        // count_q == 0 cannot occur in RUN; hold if it did.
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end

                ST_PAUSE: begin
                    // presc is left untouched so the run resumes mid-period.
                    if (!bus.pause && bus.start) begin
                        state_d = ST_RUN;
                    end
                end

                default: begin  // ST_IDLE, ST_DONE
                    if (!bus.pause && bus.start) begin
                        presc_d = '0;
                        if (reload_q != '0) begin
                            state_d = ST_RUN;
                            count_d = reload_q;
                        end else begin
                            // Zero start value terminates immediately.
                            state_d = ST_DONE;
                            count_d = '0;
                            done_d  = 1'b1;
                        end
                    end
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_ctrl
//  Description : Self-checking bench for countdown_ctrl (WIDTH=4, PRESCALE=4).
//                Vector table, directed multi-cycle sequences, and a
//                randomized run against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_ctrl;

    localparam int W = 4;
    localparam int P = 4;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    countdown_ctrl_if #(.WIDTH(W)) bus ();

    countdown_ctrl #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is a fixed number of steps, this only guards hangs.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int ec, input int eb, input int ed, input int es);
        chk({tag, ".count"}, 32'(bus.count), 32'(ec));
        chk({tag, ".busy"},  32'(bus.busy),  32'(eb));
        chk({tag, ".done"},  32'(bus.done),  32'(ed));
        chk({tag, ".state"}, 32'(bus.state), 32'(es));
    endtask

    // ------------------------------------------------------------------
    // Behavioural model (spec rules: ticks every P-th run cycle)
    // ------------------------------------------------------------------
    int m_cnt, m_rel, m_run, m_st, m_done;

    task automatic model_reset();
        m_cnt = 0; m_rel = 0; m_run = 0; m_st = 0; m_done = 0;
    endtask

    task automatic model_step(input bit l, input int v, input bit s, input bit p, input bit r);
        m_done = 0;
        if (l) begin
            m_cnt = v; m_rel = v; m_run = 0; m_st = 0;
        end else if (m_st == 1) begin
            if (p) begin
                m_st = 2;
            end else begin
                if (m_run % P == P - 1) begin
                    if (m_cnt > 1) m_cnt = m_cnt - 1;
                    else if (m_cnt == 1) begin
                        m_done = 1;
                        if (r) m_cnt = m_rel;
                        else begin m_cnt = 0; m_st = 3; end
                    end
                end
                m_run = m_run + 1;
            end
        end else if (m_st == 2) begin
            if (!p && s) m_st = 1;
        end else if (!p && s) begin
            m_run = 0;
            if (m_rel != 0) begin m_st = 1; m_cnt = m_rel; end
            else begin m_st = 3; m_cnt = 0; m_done = 1; end
        end
    endtask

    // One clock cycle: drive at negedge, model at posedge, sample 1 ns later.
    task automatic step(input bit l, input int v, input bit s, input bit p, input bit r);
        @(negedge clk);
        bus.load      = l;
        bus.load_val  = W'(v);
        bus.start     = s;
        bus.pause     = p;
        bus.repeat_en = r;
        @(posedge clk);
        model_step(l, v, s, p, r);
        #1;
    endtask

    task automatic nop(input bit r);
        step(1'b0, 0, 1'b0, 1'b0, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1 chk_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // Full single-shot countdown from val; edge k is the start step.
    task automatic run_countdown(input int val);
        step(1'b1, val, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk_out("cd_start", val, 1, 0, 1);
        for (int i = 1; i <= val * P + 3; i++) begin
            nop(1'b0);
            if (i < val * P) chk_out("cd_run", val - i / P, 1, 0, 1);
            else             chk_out("cd_end", 0, 0, (i == val * P) ? 1 : 0, 3);
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit ld; int val; bit st; bit pa; bit rp;
        int ec; int eb; int ed; int es;
    } vec_t;

    vec_t tbl[25];

    initial begin
        bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0;
        bus.pause = 1'b0; bus.repeat_en = 1'b0;
        reset = 1'b1;
        model_reset();

        //           ld val st pa rp   cnt busy done state
        tbl[0]  = '{1, 2, 0, 0, 0,   2, 0, 0, 0};   // load 2
        tbl[1]  = '{0, 0, 1, 0, 0,   2, 1, 0, 1};   // start
        tbl[2]  = '{0, 0, 0, 0, 0,   2, 1, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 0,   2, 1, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 0,   2, 1, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0,   1, 1, 0, 1};   // first tick
        tbl[6]  = '{0, 0, 0, 0, 0,   1, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 0,   1, 1, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0,   1, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0,   0, 0, 1, 3};   // terminal, done
        tbl[10] = '{0, 0, 0, 0, 0,   0, 0, 0, 3};   // done is one cycle
        tbl[11] = '{0, 0, 0, 1, 0,   0, 0, 0, 3};   // pause ignored in DONE
        tbl[12] = '{0, 0, 1, 0, 0,   2, 1, 0, 1};   // restart from reload
        tbl[13] = '{1, 7, 1, 0, 0,   7, 0, 0, 0};   // load beats start
        tbl[14] = '{0, 0, 1, 0, 0,   7, 1, 0, 1};
        tbl[15] = '{0, 0, 1, 1, 0,   7, 0, 0, 2};   // pause beats start
        tbl[16] = '{0, 0, 0, 1, 0,   7, 0, 0, 2};   // pause ignored in PAUSE
        tbl[17] = '{0, 0, 1, 0, 0,   7, 1, 0, 1};   // resume
        tbl[18] = '{0, 0, 0, 0, 0,   7, 1, 0, 1};
        tbl[19] = '{0, 0, 0, 0, 0,   7, 1, 0, 1};
        tbl[20] = '{0, 0, 0, 0, 0,   7, 1, 0, 1};
        tbl[21] = '{0, 0, 0, 0, 0,   6, 1, 0, 1};
        tbl[22] = '{1, 0, 0, 0, 0,   0, 0, 0, 0};   // load 0
        tbl[23] = '{0, 0, 1, 0, 0,   0, 0, 1, 3};   // zero start -> DONE
        tbl[24] = '{0, 0, 0, 0, 0,   0, 0, 0, 3};

        // Reset state
        repeat (2) @(negedge clk);
        chk_out("por", 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            step(tbl[i].ld, tbl[i].val, tbl[i].st, tbl[i].pa, tbl[i].rp);
            chk_out($sformatf("vec%0d", i), tbl[i].ec, tbl[i].eb, tbl[i].ed, tbl[i].es);
        end

        // Single-shot countdowns (5 and full-range 15, no wrap past 0)
        run_countdown(5);
        run_countdown(15);

        // Auto-repeat: 3,2,1,3,... done every 3*P cycles, stays RUN
        step(1'b1, 3, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 3 * 3 * P; i++) begin
            nop(1'b1);
            chk_out("rep", 3 - (i % (3 * P)) / P, 1, (i % (3 * P) == 0) ? 1 : 0, 1);
        end

        // Pause after two ticks plus one cycle, hold 10, resume
        step(1'b1, 6, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        repeat (2 * P + 1) nop(1'b0);
        chk_out("pre_pause", 4, 1, 0, 1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        chk_out("pause", 4, 0, 0, 2);
        for (int i = 0; i < 10; i++) begin
            nop(1'b0);
            chk_out("held", 4, 0, 0, 2);
        end
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk_out("resume", 4, 1, 0, 1);
        nop(1'b0); chk_out("resume+1", 4, 1, 0, 1);
        nop(1'b0); chk_out("resume+2", 4, 1, 0, 1);
        nop(1'b0); chk_out("resume+3", 3, 1, 0, 1);

        // Asynchronous reset mid-RUN, sampled before the next edge
        step(1'b1, 9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        repeat (6) nop(1'b0);
        #2 reset = 1'b1;
        #1 chk_out("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            nop(1'b0);
            chk_out("post_rst", 0, 0, 0, 0);
        end

        // Randomized run against the model
        do_reset();
        begin
            bit rp;
            rp = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                bit l, s, p;
                int v;
                l = ($urandom_range(0, 47) == 0);
                s = ($urandom_range(0, 5) == 0);
                p = ($urandom_range(0, 11) == 0);
                v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(0, 4));
                if ($urandom_range(0, 63) == 0) rp = ~rp;
                step(l, v, s, p, rp);
                chk_out("rand", m_cnt, (m_st == 1) ? 1 : 0, m_done, m_st);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the lab's 4-bit down counter datapath. It loads a start value, runs the countdown at a prescaled rate, and supports pause/resume and single-shot or auto-repeat modes. It flags terminal count with a one-cycle `done` pulse. It sits between the debounced/one-pulsed board buttons and the 7-segment/LED display path, and owns the counter register directly.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `PRESCALE`, default 4: clock cycles per decrement tick; must be ≥1.
- `clk`  in  1: single system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `load`  in  1: one-cycle pulse; capture `load_val`.
- `load_val`  in  WIDTH: start value.
- `start`  in  1: one-cycle pulse; start or resume.
- `pause`  in  1: one-cycle pulse; suspend counting.
- `repeat_en`  in  1: level; 1 = auto-reload at terminal count.
- `count`  out  WIDTH: current counter value.
- `busy`  out  1: high while state is RUN.
- `done`  out  1: one-cycle terminal-count pulse.
- `state`  out  2: encoding IDLE=0, RUN=1, PAUSE=2, DONE=3.

## Operation
- Internal registers:
  - `count`.
  - `reload` (WIDTH): last loaded value.
  - `presc` (0..PRESCALE-1).
  - `state`.
- Input priority within a cycle: `load` > `pause` > `start`. Lower-priority pulses in the same cycle are dropped.
- `load` in any state:
  - `count` ← `load_val`, `reload` ← `load_val`, `presc` ← 0.
  - state → IDLE.
  - No `done` pulse.
- IDLE + `start`:
  - If `reload`≠0: state → RUN, `count` ← `reload`, `presc` ← 0.
  - If `reload`==0: state → DONE, `count` ← 0, `done` pulses.
- RUN:
  - `presc` increments each cycle and wraps to 0 after PRESCALE-1.
  - A tick occurs in a RUN cycle with `presc`==PRESCALE-1.
  - On a tick with `count`>1: `count` ← `count`-1.
  - On a tick with `count`==1 and `repeat_en`=0: `count` ← 0, state → DONE, `done` pulses.
  - On a tick with `count`==1 and `repeat_en`=1: `count` ← `reload`, state stays RUN, `done` pulses.
- RUN + `pause`: state → PAUSE. `presc` and `count` hold. A tick in that same cycle is suppressed.
- PAUSE:
  - `start` → RUN; `presc` resumes from its held value.
  - `pause` is ignored.
- DONE: `count` holds 0.
  - `start` behaves as in IDLE (restart from `reload`).
  - `pause` is ignored.
- `start` while in RUN is ignored.
- Arithmetic is unsigned WIDTH-bit. `count` never underflows: the 1→0 transition is terminal, and 0 is never decremented.
- `repeat_en` is sampled only at the terminal tick. Changing it mid-run affects the next terminal tick only.

## Timing
- Reset, asynchronous on assertion: `count`=0, `reload`=0, `presc`=0, state=IDLE, `busy`=0, `done`=0.
- Release is synchronous to `clk`. The first active edge after deassertion is a normal cycle.
- All outputs are registered; none is a combinational function of inputs.
- `load` sampled at edge k: new `count` is visible after edge k.
- `start` sampled at edge k (IDLE, `reload`=N≠0):
  - RUN and `busy` after edge k.
  - `count` becomes N-1 after edge k+PRESCALE.
  - `count` reaches 0 after edge k+N·PRESCALE.
  - `done` is high for exactly the cycle following that edge.
- `done` is never high for two consecutive cycles.
- After a pause held P cycles, total run latency extends by exactly P+1 cycles. The +1 is the resume `start` cycle.
- `reset` asserted mid-RUN: all registers return to reset values immediately. No `done` is emitted.

## Test plan
- Reset, then check outputs. Then `load` 5 (PRESCALE=4) and `start` at edge k → `count` sequence 5,4,3,2,1,0 changing at k+4, +8, +12, +16, +20. `done`=1 only in the cycle after k+20. State DONE, `busy`=0.
- `repeat_en`=1, load 3, start → `count` runs 3,2,1,3,2,1… `done` pulses every 12 cycles. State stays RUN.
- Load 6, start; `pause` after 2 ticks plus 1 cycle; hold 10 cycles; `start` → `count` frozen at 4 throughout PAUSE. The next tick arrives 3 cycles after resume (`presc` preserved).
- Same-cycle `load`+`start` in RUN → `load` wins: state IDLE, `count`=`load_val`, no `done`. Same-cycle `pause`+`start` in RUN → PAUSE.
- `start` with `reload`=0 after reset → state DONE next cycle, single `done` pulse, `count`=0. Then load 15, start → full 15-step countdown with no wrap past 0.
- Assert `reset` asynchronously mid-RUN (between edges) → `count`=0 and state IDLE before the next edge. No `done` pulse.
